// File: rtl/siso_alpha_recursion.sv
// siso_alpha_recursion: max-log-MAP forward alpha recursion for the 8-state LTE code, normalized to state 0
module siso_alpha_recursion #(
  parameter int BW = 16,
  parameter int AW = 16,
  parameter int INIT_NEG = -4096,
  parameter int LW = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [BW-1:0] branch1,
  input  logic signed [BW-1:0] branch2,
  input  logic                 valid_in,
  input  logic [LW-1:0]        blklen,
  output logic [8*AW-1:0]      alpha_out,
  output logic [LW-1:0]        step_out,
  output logic                 valid_out,
  output logic                 last_out
);
  localparam int SW = AW + 2;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  localparam logic signed [SW-1:0] MAXV = SW'(2 ** (AW - 1) - 1);
  localparam logic signed [SW-1:0] MINV = -SW'(2 ** (AW - 1));
  logic [0:0] state_q, state_d;
  logic [LW-1:0] k_q, k_d, len_q, len_d, len_cur, k_cur;
  logic signed [AW-1:0] met_q [8];
  logic signed [AW-1:0] met_d [8];
  logic signed [AW-1:0] met_n [8];
  logic signed [AW-1:0] met_i [8];
  logic signed [SW-1:0] un [8];
  logic signed [SW-1:0] g1, g2, g, cand, d;
  logic [2:0] ns;
  logic a, p, last;
  logic [8*AW-1:0] norm;
  always_comb begin
    g1 = SW'(branch1);
    g2 = SW'(branch2);
    g = '0;
    cand = '0;
    d = '0;
    ns = '0;
    a = 1'b0;
    p = 1'b0;
    norm = '0;
    for (int s = 0; s < 8; s++) begin
      un[s] = {1'b1, {(SW - 1){1'b0}}};
      met_i[s] = (s == 0) ? '0 : AW'(INIT_NEG);
    end
    // add-compare-select over both branches leaving every state
    for (int s = 0; s < 8; s++) begin
      for (int u = 0; u < 2; u++) begin
        a = u[0] ^ s[1] ^ s[0];
        p = a ^ s[2] ^ s[0];
        ns = {a, s[2], s[1]};
        g = u[0] ? (p ? g1 : g2) : (p ? -g2 : -g1);
        cand = SW'(met_q[s]) + g;
        if (cand > un[ns]) un[ns] = cand;
      end
    end
    for (int s = 0; s < 8; s++) begin
      d = un[s] - un[0];
      met_n[s] = (d > MAXV) ? MAXV[AW-1:0] : (d < MINV) ? MINV[AW-1:0] : d[AW-1:0];
      norm[AW*s +: AW] = met_n[s];
    end
  end
  always_comb begin
    len_cur = (state_q == IDLE) ? ((blklen == '0) ? LW'(1) : blklen) : len_q;
    k_cur = (state_q == IDLE) ? '0 : k_q;
    last = (k_cur == len_cur - 1'b1);
    state_d = state_q;
    k_d = k_q;
    len_d = len_q;
    met_d = met_q;
    if (valid_in) begin
      len_d = len_cur;
      state_d = last ? IDLE : RUN;
      k_d = last ? '0 : k_cur + 1'b1;
      met_d = last ? met_i : met_n;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q <= '0;
      len_q <= '0;
      met_q <= met_i;
      alpha_out <= '0;
      step_out <= '0;
      valid_out <= 1'b0;
      last_out <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      len_q <= len_d;
      met_q <= met_d;
      valid_out <= valid_in;
      last_out <= valid_in && last;
      if (valid_in) begin
        alpha_out <= norm;
        step_out <= k_cur;
      end
    end
  end
endmodule
